// File: rtl/iiitb_sqd_1010.sv
// -----------------------------------------------------------------------------
// iiitb_sqd_1010
// Serial detector for the pattern 1-0-1-0. It samples one bit per rising clock
// edge and raises y for one cycle once the final 0 has been sampled. This is a
// Moore machine, so y is decoded from the state register only.
//
// Ports
//   din   : serial data bit, sampled on posedge clk
//   reset : synchronous reset, active-low (0 = reset)
//   clk   : rising-edge clock
//   y     : detection flag, high while the full pattern has just been seen
//
// Parameters
//   OVERLAP : 1 = the trailing "10" of a match can start the next match
//             0 = detection restarts from scratch after a match
//
// State encoding (3-bit binary)
//   state | code | meaning
//   S0    | 000  | idle, nothing matched
//   S1    | 001  | "1" matched
//   S10   | 010  | "10" matched
//   S101  | 011  | "101" matched
//   S1010 | 100  | full match, y = 1
//   --    | 101, 110, 111 | unused, return to S0 on the next edge
// -----------------------------------------------------------------------------
module iiitb_sqd_1010 #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic din,
  input  logic reset,
  input  logic clk,
  output logic y
);

  typedef enum logic [2:0] {
    S0    = 3'b000,
    S1    = 3'b001,
    S10   = 3'b010,
    S101  = 3'b011,
    S1010 = 3'b100
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register. This is the only sequential element in the block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = din ? S1   : S0;
      S1:      w_next = din ? S1   : S10;
      S10:     w_next = din ? S101 : S0;
      S101:    w_next = din ? S1   : S1010;
      // With overlap enabled, the "10" just matched plus a new 1 forms "101".
      S1010:   w_next = din ? (OVERLAP ? S101 : S1) : S0;
      default: w_next = S0;
    endcase
  end

  // Output decode. It depends only on the state, so there is no path from din.
  always_comb begin
    y = 1'b0;
    if (r_state == S1010) begin
      y = 1'b1;
    end
  end

endmodule

// File: tb/tb_iiitb_sqd_1010.sv
// -----------------------------------------------------------------------------
// tb_iiitb_sqd_1010
// Two instances of the detector are driven from the same stream. One has
// OVERLAP=1 and the other has OVERLAP=0.
//
// Each expected value comes from a behavioural model:
//   - A queue holds the last bits received since reset.
//   - y is 1 when the last four bits are 1,0,1,0.
//   - In non-overlap mode the history is cleared after each match.
//
// Stimulus pushes the expected y values into a scoreboard. A separate monitor
// pops one entry and compares it with the outputs after each clock edge.
// -----------------------------------------------------------------------------
module tb_iiitb_sqd_1010;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic din   = 1'b0;
  logic y_ov;
  logic y_no;

  always #5 clk = ~clk;

  iiitb_sqd_1010 #(.OVERLAP(1'b1)) dut_ov (
    .din  (din),
    .reset(reset),
    .clk  (clk),
    .y    (y_ov)
  );

  iiitb_sqd_1010 #(.OVERLAP(1'b0)) dut_no (
    .din  (din),
    .reset(reset),
    .clk  (clk),
    .y    (y_no)
  );

  typedef struct {
    bit e_ov;
    bit e_no;
    int step;
  } exp_t;

  exp_t sb[$];
  bit   h_ov[$];
  bit   h_no[$];
  int   checks = 0;
  int   errors = 0;
  int   n_step = 0;

  // Drive one bit. The model result is pushed for the edge that samples it.
  task automatic step(input bit r, input bit d);
    exp_t e;
    @(negedge clk);
    reset = r;
    din   = d;
    if (!r) begin
      h_ov.delete();
      h_no.delete();
      e.e_ov = 1'b0;
      e.e_no = 1'b0;
    end else begin
      h_ov.push_back(d);
      if (h_ov.size() > 4) void'(h_ov.pop_front());
      e.e_ov = (h_ov.size() == 4) && h_ov[0] && !h_ov[1] && h_ov[2] && !h_ov[3];

      h_no.push_back(d);
      if (h_no.size() > 4) void'(h_no.pop_front());
      e.e_no = (h_no.size() == 4) && h_no[0] && !h_no[1] && h_no[2] && !h_no[3];
      if (e.e_no) h_no.delete();
    end
    n_step++;
    e.step = n_step;
    sb.push_back(e);
  endtask

  // Play n bits of 'bits' MSB first with reset released.
  task automatic play(input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  // Monitor: sample 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (y_ov !== e.e_ov) begin
          errors++;
          $display("FAIL y_overlap step %0d: got %b expected %b", e.step, y_ov, e.e_ov);
        end
        checks++;
        if (y_no !== e.e_no) begin
          errors++;
          $display("FAIL y_nonoverlap step %0d: got %b expected %b", e.step, y_no, e.e_no);
        end
      end
    end
  end

  // Watchdog: stop the run if it takes far longer than expected.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for several edges while din toggles.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Single match followed by zeros.
    play(4, 16'b1010);
    play(2, 16'b00);

    // Back-to-back overlapping stream.
    play(6, 16'b101010);
    play(2, 16'b00);

    // Near misses; only the final 0 completes a match.
    play(11, 16'b11011001010);
    play(1, 16'b0);

    // Mid-sequence reset discards the partial "101".
    play(3, 16'b101);
    step(1'b0, 1'b0);
    play(1, 16'b0);
    play(4, 16'b1010);
    play(1, 16'b0);

    // Reset on the edge after a full match.
    play(4, 16'b1010);
    step(1'b0, 1'b1);
    play(3, 16'b010);
    play(2, 16'b00);

    // Randomized stream with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 39) != 0), $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
